// File: rtl/csel_pkg.sv
// Shared types and default constants for the csel drive/free request source.
package csel_pkg;

  localparam int unsigned CSEL_DATA_W  = 32;
  localparam int unsigned CSEL_DRIVE_W = 2;
  localparam int unsigned CSEL_TIMEOUT = 255;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    DRIVE = 2'd2,
    WAIT  = 2'd3
  } state_t;

  // Request payload at the default bus width: branch select plus data.
  typedef struct packed {
    logic                   sel;
    logic [CSEL_DATA_W-1:0] data;
  } req_t;

endpackage

// File: rtl/csel_sync_pulse.sv
// Two-flop synchronizer followed by a rising-edge detector.
// Reused for any free/drive pulse crossing into the clk domain.
module csel_sync_pulse (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise_c
);

  // [0],[1] form the synchronizer; [2] holds the previous synchronized value.
  logic [2:0] shift;

  always_ff @(posedge clk) begin
    if (rst) begin
      shift <= '0;
    end else begin
      shift <= {shift[1:0], async_in};
    end
  end

  assign rise_c = shift[1] & ~shift[2];

endmodule

// File: rtl/csel_drive_src.sv
// Buffered request source for the two-way conditional split's drive/free handshake.
// Optional free-wait watchdog and err_timeout port: define CSEL_SRC_WDOG_EN.
module csel_drive_src
  import csel_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = CSEL_DATA_W,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DRIVE_W    = CSEL_DRIVE_W,
  parameter int unsigned TIMEOUT    = CSEL_TIMEOUT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DATA_WIDTH-1:0]         s_data,
  input  logic                          s_sel,
  output logic                          o_drive,
  output logic                          valid0,
  output logic                          valid1,
  output logic [DATA_WIDTH-1:0]         o_data,
  input  logic                          i_free,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef CSEL_SRC_WDOG_EN
  ,
  output logic                          err_timeout
`endif
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = (DRIVE_W > 1) ? $clog2(DRIVE_W) : 1;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || DRIVE_W < 1 || TIMEOUT < 1)
  begin : g_bad_params
    $error("csel_drive_src: illegal parameter set");
  end

  state_t                state, state_d;
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [LW-1:0]         level_d;
  logic [DATA_WIDTH:0]   mem [FIFO_DEPTH];
  logic [DATA_WIDTH:0]   head;
  logic                  push, pop;
  logic                  free_rise;
  logic                  free_seen, free_seen_d;
  logic [CW-1:0]         drv_cnt, drv_cnt_d;
  logic                  drive_d, valid0_d, valid1_d;
  logic [DATA_WIDTH-1:0] o_data_d;

`ifdef CSEL_SRC_WDOG_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wd_cnt, wd_cnt_d;
  logic          err_d;
`endif

  csel_sync_pulse u_free_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (i_free),
    .rise_c   (free_rise)
  );

  assign push    = s_valid & s_ready;
  assign head    = mem[rd_ptr];
  assign level_d = fifo_level + LW'(push) - LW'(pop);

  // Entry storage: {sel, data}; no reset needed, occupancy is tracked by pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {s_sel, s_data};
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state;
    free_seen_d = free_seen;
    drv_cnt_d   = drv_cnt;
    drive_d     = 1'b0;
    valid0_d    = valid0;
    valid1_d    = valid1;
    o_data_d    = o_data;
    pop         = 1'b0;
`ifdef CSEL_SRC_WDOG_EN
    wd_cnt_d    = wd_cnt;
    err_d       = err_timeout;
`endif
    unique case (state)
      IDLE: begin
        free_seen_d = 1'b0;
        if (fifo_level != '0) begin
          pop      = 1'b1;
          o_data_d = head[DATA_WIDTH-1:0];
          valid0_d = ~head[DATA_WIDTH];
          valid1_d = head[DATA_WIDTH];
          state_d  = SETUP;
        end
      end
      SETUP: begin
        if (free_rise) free_seen_d = 1'b1;
        drv_cnt_d = '0;
        drive_d   = 1'b1;
        state_d   = DRIVE;
      end
      DRIVE: begin
        if (free_rise) free_seen_d = 1'b1;
        if (drv_cnt == CW'(DRIVE_W - 1)) begin
          // A free that already arrived lets us skip WAIT entirely.
          if (free_seen || free_rise) begin
            valid0_d    = 1'b0;
            valid1_d    = 1'b0;
            free_seen_d = 1'b0;
            state_d     = IDLE;
          end else begin
`ifdef CSEL_SRC_WDOG_EN
            wd_cnt_d = '0;
`endif
            state_d  = WAIT;
          end
        end else begin
          drv_cnt_d = drv_cnt + CW'(1);
          drive_d   = 1'b1;
        end
      end
      WAIT: begin
        if (free_rise) begin
          valid0_d = 1'b0;
          valid1_d = 1'b0;
          state_d  = IDLE;
        end
`ifdef CSEL_SRC_WDOG_EN
        else if (wd_cnt == TW'(TIMEOUT - 1)) begin
          valid0_d = 1'b0;
          valid1_d = 1'b0;
          err_d    = 1'b1;
          state_d  = IDLE;
        end else begin
          wd_cnt_d = wd_cnt + TW'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      s_ready    <= 1'b1;
      busy       <= 1'b0;
      o_drive    <= 1'b0;
      valid0     <= 1'b0;
      valid1     <= 1'b0;
      o_data     <= '0;
      free_seen  <= 1'b0;
      drv_cnt    <= '0;
    end else begin
      state      <= state_d;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      fifo_level <= level_d;
      s_ready    <= (level_d != LW'(FIFO_DEPTH));
      busy       <= (state_d != IDLE);
      o_drive    <= drive_d;
      valid0     <= valid0_d;
      valid1     <= valid1_d;
      o_data     <= o_data_d;
      free_seen  <= free_seen_d;
      drv_cnt    <= drv_cnt_d;
    end
  end

`ifdef CSEL_SRC_WDOG_EN
  // Watchdog counter and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt      <= '0;
      err_timeout <= 1'b0;
    end else begin
      wd_cnt      <= wd_cnt_d;
      err_timeout <= err_d;
    end
  end
`endif

endmodule
